apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Single-outstanding APB3 requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward the 8-bit APB slave memory.
- Returns read data and error status on a one-cycle response strobe.
- Adds a programmable PREADY timeout so that a hung slave cannot lock up the requester.

Parameters:
ADDR_W, 8, APB address width (PADDR, cmd_addr)
DATA_W, 8, APB data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before forced error termination (>=2)

Ports:
PCLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at PCLK edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  PSLVERR or timeout on completed transfer
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (RST=1 at edge): state=IDLE; PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. Reset mid-transfer aborts immediately; no response is issued.
- All APB and rsp outputs are registered. cmd_ready is combinational: asserted only when state==IDLE and RST=0.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. On cmd accept, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, exactly 1 cycle, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable. Stay in ACCESS while PREADY=0.
- ACCESS completion on PREADY=1 at an edge:
  - Next cycle: rsp_valid=1 for exactly one cycle.
  - rsp_err=PSLVERR.
  - rsp_rdata=PRDATA if read and PSLVERR=0, else 0.
  - PSEL=PENABLE=0, state=IDLE.
- No back-to-back pipelining: minimum 3 cycles between accepts (IDLE accept, SETUP, ACCESS). Each transfer has at least one IDLE cycle with PSEL=0 after it.
- Timeout:
  - Counter clears on SETUP entry and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT-1 with PREADY still 0: terminate the transfer with rsp_valid=1, rsp_err=1, rsp_rdata=0; drop PSEL/PENABLE; return to IDLE.
  - A PREADY arriving in the same cycle as the timeout takes priority and is a normal completion.
  - Counter width is sized for TIMEOUT with no wrap.
- PREADY, PRDATA and PSLVERR are ignored outside ACCESS. A spurious PREADY in IDLE or SETUP causes no response and no state change.
- cmd_valid while busy is not accepted (cmd_ready=0). The command source must hold its inputs until accepted.
- rsp_valid may coincide with cmd_ready=1 in the same cycle. A command accepted then starts normally.

Test Plan:
1. Write: cmd_write=1, addr=0x10, wdata=0xA5, slave PREADY 1 cycle after PENABLE -> PSEL rises the cycle after accept, PENABLE one cycle later; PADDR=0x10 and PWDATA=0xA5 stable throughout; rsp_valid pulse with rsp_err=0, rsp_rdata=0.
2. Read back 0x10 -> rsp_rdata=0xA5, rsp_err=0; PWRITE=0 throughout SETUP/ACCESS.
3. Slave error: read of addr=0x02, slave returns PSLVERR=1 with PREADY -> rsp_err=1, rsp_rdata=0x00; next command accepted normally.
4. Wait states: PREADY held low 5 ACCESS cycles, TIMEOUT=16 -> PENABLE high 6 cycles, address/data stable, single rsp_valid, rsp_err=0.
5. Timeout: PREADY tied 0, TIMEOUT=16 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, PSEL=0; a later PREADY pulse in IDLE is ignored.
6. Reset mid-ACCESS: assert RST for 1 cycle while PENABLE=1 -> next cycle all outputs 0, no rsp_valid; cmd_ready=1 the cycle after RST deasserts.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Bundles the command, response and APB signals of the APB master bridge.
//   master modport: the bridge's own view. It takes in the command and the slave's
//     PREADY/PRDATA/PSLVERR, and drives cmd_ready, the response and the APB request.
//   slave modport: the view of the environment around the bridge, which is the command
//     source, the response sink and the APB slave.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // Response strobe
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  // APB3 requester side
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester with one transfer outstanding at a time. It turns a valid/ready command
// into an APB SETUP/ACCESS transfer, then returns the result on a one-cycle response strobe.
// A programmable PREADY timeout ends a transfer that the slave never completes.
// Ports:
//   PCLK - clock; all logic runs on its rising edge
//   RST  - synchronous reset, active-high; aborts any transfer without sending a response
//   bus  - command, response and APB signals (master modport of apb_master_bridge_if)
// Every APB and response output comes from a register. cmd_ready is combinational.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 PCLK,
  input logic                 RST,
  apb_master_bridge_if.master bus
);

  // Just wide enough to count up to TIMEOUT-1, so the counter never wraps.
  localparam int unsigned    CntW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cmd_ready;

  assign cmd_ready = (state_q == StIdle) && !RST;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    // The response registers only carry a value for the single strobe cycle.
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end

      StAccess: begin
        // PREADY wins over a timeout that expires in the same cycle.
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.PSLVERR;
          rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = StIdle;
        end else if (cnt_q == CntMax) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=16). Outputs are sampled 1 time unit after
// each rising edge. Inputs are changed right after sampling.
module tb_apb_master_bridge;

  logic PCLK;
  logic RST;
  int   n_vec;
  int   n_err;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_bridge #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK),
    .RST (RST),
    .bus (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".psel"}, 32'(bus.PSEL), 32'd0);
    chk({tag, ".penable"}, 32'(bus.PENABLE), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 8'h00;
    bus.PSLVERR   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst.pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst.paddr", 32'(bus.PADDR), 32'd0);
    chk("rst.pwdata", 32'(bus.PWDATA), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    RST = 1'b0;
    #1;
    chk("rst.cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

    // 1. Write 0xA5 to 0x10. A spurious PREADY in SETUP must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h10;
    bus.cmd_wdata = 8'hA5;
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr.setup.psel", 32'(bus.PSEL), 32'd1);
    chk("wr.setup.penable", 32'(bus.PENABLE), 32'd0);
    chk("wr.setup.pwrite", 32'(bus.PWRITE), 32'd1);
    chk("wr.setup.paddr", 32'(bus.PADDR), 32'h10);
    chk("wr.setup.pwdata", 32'(bus.PWDATA), 32'hA5);
    chk("wr.setup.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.PREADY = 1'b1;
    tick();
    chk("wr.access.penable", 32'(bus.PENABLE), 32'd1);
    chk("wr.access.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("wr.access.paddr", 32'(bus.PADDR), 32'h10);
    chk("wr.access.pwdata", 32'(bus.PWDATA), 32'hA5);
    tick();
    bus.PREADY = 1'b0;
    chk_idle("wr.rsp");
    chk("wr.rsp.valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr.rsp.err", 32'(bus.rsp_err), 32'd0);
    chk("wr.rsp.rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("wr.rsp.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("wr.post.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // 2. Read back 0x10
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h10;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd.setup.pwrite", 32'(bus.PWRITE), 32'd0);
    tick();
    chk("rd.access.pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rd.access.penable", 32'(bus.PENABLE), 32'd1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'hA5;
    tick();
    bus.PREADY = 1'b0;
    chk("rd.rsp.valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd.rsp.rdata", 32'(bus.rsp_rdata), 32'hA5);
    chk("rd.rsp.err", 32'(bus.rsp_err), 32'd0);
    tick();

    // 3. Slave error on a read of 0x02
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 8'h02;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 8'h5A;
    tick();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    chk("err.rsp.valid", 32'(bus.rsp_valid), 32'd1);
    chk("err.rsp.err", 32'(bus.rsp_err), 32'd1);
    chk("err.rsp.rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("err.rsp.cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 4. Accept the next command in the response cycle. The slave then adds 5 wait states.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h33;
    bus.cmd_wdata = 8'h3C;
    tick();
    bus.cmd_valid = 1'b0;
    chk("ws.setup.psel", 32'(bus.PSEL), 32'd1);
    chk("ws.setup.paddr", 32'(bus.PADDR), 32'h33);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ws.wait%0d.penable", i), 32'(bus.PENABLE), 32'd1);
      chk($sformatf("ws.wait%0d.paddr", i), 32'(bus.PADDR), 32'h33);
      chk($sformatf("ws.wait%0d.pwdata", i), 32'(bus.PWDATA), 32'h3C);
      chk($sformatf("ws.wait%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    chk("ws.last.penable", 32'(bus.PENABLE), 32'd1);
    chk("ws.last.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.PREADY = 1'b1;
    tick();
    bus.PREADY = 1'b0;
    chk("ws.rsp.valid", 32'(bus.rsp_valid), 32'd1);
    chk("ws.rsp.err", 32'(bus.rsp_err), 32'd0);
    chk_idle("ws.rsp");
    tick();
    chk("ws.post.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // 5. Timeout: PREADY is never asserted, so the bridge ends the transfer after 16 ACCESS cycles
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h44;
    bus.PRDATA    = 8'hEE;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to.acc%0d.penable", i), 32'(bus.PENABLE), 32'd1);
      chk($sformatf("to.acc%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    chk("to.rsp.valid", 32'(bus.rsp_valid), 32'd1);
    chk("to.rsp.err", 32'(bus.rsp_err), 32'd1);
    chk("to.rsp.rdata", 32'(bus.rsp_rdata), 32'd0);
    chk_idle("to.rsp");
    tick();
    bus.PREADY = 1'b1;
    tick();
    bus.PREADY = 1'b0;
    chk("to.spurious.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk_idle("to.spurious");
    chk("to.spurious.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("to.spurious2.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // 5b. PREADY arrives in the last ACCESS cycle and counts as a normal completion
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 8'h55;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("pri.acc15.penable", 32'(bus.PENABLE), 32'd1);
    chk("pri.acc15.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h77;
    tick();
    bus.PREADY = 1'b0;
    chk("pri.rsp.valid", 32'(bus.rsp_valid), 32'd1);
    chk("pri.rsp.err", 32'(bus.rsp_err), 32'd0);
    chk("pri.rsp.rdata", 32'(bus.rsp_rdata), 32'h77);
    tick();

    // 6. Reset during ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h66;
    bus.cmd_wdata = 8'h99;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("mr.access.penable", 32'(bus.PENABLE), 32'd1);
    RST = 1'b1;
    tick();
    chk_idle("mr.rst");
    chk("mr.rst.pwrite", 32'(bus.PWRITE), 32'd0);
    chk("mr.rst.paddr", 32'(bus.PADDR), 32'd0);
    chk("mr.rst.pwdata", 32'(bus.PWDATA), 32'd0);
    chk("mr.rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr.rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    RST = 1'b0;
    #1;
    chk("mr.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("mr.post.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk_idle("mr.post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
